// File: rtl/fir_coeff_store_if.sv
// Coefficient-reload bus between fir_coeff_master and fir_coeff_store.
// The master drives writes, readback requests and the sync clear; the store
// returns readback beats, the active coefficient set, the update strobe and
// sticky error flags.
interface fir_coeff_store_if #(
   parameter int COEFF_W = 8,
   parameter int LANES   = 4,
   parameter int GROUPS  = 4,
   parameter int LANE_W  = 16
);
   localparam int ADR_W = $clog2(GROUPS);

   // master -> store
   logic                            coeff_areset;
   logic [LANES-1:0]                coeff_we;
   logic [ADR_W-1:0]                coeff_adr;
   logic [LANES*LANE_W-1:0]         coeff_in_data;
   logic                            coeff_read;

   // store -> master / filter datapath
   logic [LANES-1:0]                coeff_out_valid;
   logic [LANES*LANE_W-1:0]         coeff_out_data;
   logic [LANES*GROUPS*COEFF_W-1:0] coeff_active;
   logic                            coeff_update;
   logic [7:0]                      err_out;

   modport master (
      output coeff_areset, coeff_we, coeff_adr, coeff_in_data, coeff_read,
      input  coeff_out_valid, coeff_out_data, coeff_active, coeff_update, err_out
   );

   modport slave (
      input  coeff_areset, coeff_we, coeff_adr, coeff_in_data, coeff_read,
      output coeff_out_valid, coeff_out_data, coeff_active, coeff_update, err_out
   );
endinterface

// File: rtl/fir_coeff_store.sv
// FIR coefficient store: shadow bank filled lane-by-lane, committed atomically
// to the active bank once every tap has been written in the current round.
// The active bank can be read back as a GROUPS-beat burst taken from a
// snapshot, so a commit during the burst never tears the returned set.
module fir_coeff_store #(
   parameter int COEFF_W = 8,
   parameter int LANES   = 4,
   parameter int GROUPS  = 4,
   parameter int LANE_W  = 16
) (
   input logic                 clk,
   input logic                 rst,
   fir_coeff_store_if.slave    bus
);

   localparam int TAPS       = LANES * GROUPS;
   localparam int ADR_W      = $clog2(GROUPS);
   localparam int LANE_IDX_W = $clog2(LANES);
   localparam int BEAT_W     = ADR_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_BEAT = 2'd2
   } state_t;

   // Widen a stored coefficient to a full readback lane.
   function automatic logic [LANE_W-1:0] sext(input logic [COEFF_W-1:0] c);
      return {{(LANE_W-COEFF_W){c[COEFF_W-1]}}, c};
   endfunction

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [COEFF_W-1:0]      shadow_q   [TAPS];
   logic [COEFF_W-1:0]      active_q   [TAPS];
   logic [COEFF_W-1:0]      snapshot_q [TAPS];
   logic [TAPS-1:0]         mask_q, mask_d;
   logic [2:0]              err_q, err_d;
   logic                    update_q;

   state_t                  state_q;
   logic [BEAT_W-1:0]       beat_q;
   logic [LANES-1:0]        valid_q;
   logic [LANES*LANE_W-1:0] data_q;

   // ------------------------------------------------------------------
   // Lane decode
   // ------------------------------------------------------------------
   logic [LANE_W-1:0]       lane_data [LANES];
   logic [LANES-1:0]        lane_wr;
   logic [LANES-1:0]        lane_dup;
   logic [LANES-1:0]        lane_ext_bad;
   logic [TAPS-1:0]         wr_tap;
   logic [COEFF_W-1:0]      tap_wdata [TAPS];
   logic [TAPS-1:0]         mask_base;
   logic                    commit;
   logic                    read_err;
   logic [LANES*LANE_W-1:0] beat_word;

   // A full mask means the round is complete; the sync clear cancels it.
   assign commit = (&mask_q) & ~bus.coeff_areset;

   // The commit cycle already starts a fresh round, so writes landing in it
   // see an empty mask and cannot be flagged as rewrites.
   assign mask_base = ((&mask_q) | bus.coeff_areset) ? '0 : mask_q;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_data[gi]    = bus.coeff_in_data[gi*LANE_W +: LANE_W];
         assign lane_wr[gi]      = bus.coeff_we[gi] & ~bus.coeff_areset;
         assign lane_dup[gi]     = lane_wr[gi] &
                                   mask_base[{bus.coeff_adr, LANE_IDX_W'(gi)}];
         assign lane_ext_bad[gi] = lane_wr[gi] &
            (lane_data[gi][LANE_W-1:COEFF_W] !=
             {(LANE_W-COEFF_W){lane_data[gi][COEFF_W-1]}});
         // Readback lane for the current beat, sign-extended from the snapshot.
         assign beat_word[gi*LANE_W +: LANE_W] =
            sext(snapshot_q[{beat_q, LANE_IDX_W'(gi)}]);
      end

      for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
         assign wr_tap[gi]    = lane_wr[gi % LANES] &
                                (bus.coeff_adr == ADR_W'(gi / LANES));
         assign tap_wdata[gi] = lane_data[gi % LANES][COEFF_W-1:0];
         assign bus.coeff_active[gi*COEFF_W +: COEFF_W] = active_q[gi];
      end
   endgenerate

   assign read_err = bus.coeff_read & ~bus.coeff_areset & (state_q != IDLE);

   // Next round mask and sticky error flags.
   always_comb begin
      mask_d = mask_base | wr_tap;
      if (bus.coeff_areset) begin
         err_d = '0;
      end else begin
         err_d = err_q | {|lane_ext_bad, |lane_dup, read_err};
      end
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // Shadow bank: each written lane stores its low byte into its tap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < TAPS; t++) shadow_q[t] <= '0;
      end else begin
         for (int t = 0; t < TAPS; t++) begin
            if (wr_tap[t]) shadow_q[t] <= tap_wdata[t];
         end
      end
   end

   // Round tracking and error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '0;
         err_q  <= '0;
      end else begin
         mask_q <= mask_d;
         err_q  <= err_d;
      end
   end

   // Active bank: atomic copy of the completed shadow, with a one-cycle strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int t = 0; t < TAPS; t++) active_q[t] <= '0;
         update_q <= 1'b0;
      end else begin
         update_q <= commit;
         if (commit) begin
            for (int t = 0; t < TAPS; t++) active_q[t] <= shadow_q[t];
         end
      end
   end

   // Readback FSM: snapshot on request, one wait cycle, then one beat per
   // address group with all lanes valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         valid_q <= '0;
         data_q  <= '0;
         for (int t = 0; t < TAPS; t++) snapshot_q[t] <= '0;
      end else if (bus.coeff_areset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         valid_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= '0;
               if (bus.coeff_read) begin
                  for (int t = 0; t < TAPS; t++) snapshot_q[t] <= active_q[t];
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               valid_q <= '0;
               beat_q  <= '0;
               state_q <= RD_BEAT;
            end
            RD_BEAT: begin
               valid_q <= '1;
               data_q  <= beat_word;
               beat_q  <= beat_q + 1'b1;
               if (beat_q == BEAT_W'(GROUPS-1)) state_q <= IDLE;
            end
            default: begin
               valid_q <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.coeff_out_valid = valid_q;
   assign bus.coeff_out_data  = data_q;
   assign bus.coeff_update    = update_q;
   assign bus.err_out         = {5'b0, err_q};

endmodule
